// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor with valid/ready handshakes.
// Processes DIGIT bits per cycle, LSB first; WIDTH/DIGIT cycles per operation.
module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("addsub_serial: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  logic             carry_q;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] s_dig;
  logic             c_out;
  logic             c_msb;
  logic [WIDTH-1:0] res_nxt;

  always_comb begin
    a_dig          = a_q[int'(cnt)*DIGIT +: DIGIT];
    b_dig          = b_q[int'(cnt)*DIGIT +: DIGIT];
    {c_out, s_dig} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    // Carry into the top bit of this digit, recovered from its sum bit.
    c_msb          = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ s_dig[DIGIT-1];
    res_nxt        = result;
    res_nxt[int'(cnt)*DIGIT +: DIGIT] = s_dig;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= StIdle;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid && !flush) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            sub_q   <= sub;
            carry_q <= sub ? ~cin : cin;
            cnt     <= '0;
            state   <= StRun;
          end
        end
        StRun: begin
          if (flush) begin
            cnt   <= '0;
            state <= StIdle;
          end else begin
            result  <= res_nxt;
            carry_q <= c_out;
            if (cnt == LastCnt) begin
              cout  <= sub_q ^ c_out;
              ovf   <= c_msb ^ c_out;
              zero  <= (res_nxt == '0);
              cnt   <= '0;
              state <= StDone;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        StDone: begin
          if (flush || out_ready) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign in_ready  = rst_n && (state == StIdle);
  assign out_valid = (state == StDone);

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial: four instances (DIGIT = 2, 1, 4, 8) share stimulus;
// per-instance monitors pop expected results and check latency.
module tb_addsub_serial;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       cin;
    logic [7:0] res;
    logic       co;
    logic       ov;
    logic       z;
  } vec_t;

  typedef struct packed {
    logic [7:0]  res;
    logic        co;
    logic        ov;
    logic        z;
    logic [31:0] acc;
  } exp_t;

  localparam int NV = 11;
  vec_t vecs [NV] = '{
    '{8'h3C, 8'h15, 1'b0, 1'b0, 8'h51, 1'b0, 1'b0, 1'b0},
    '{8'h15, 8'h3C, 1'b1, 1'b0, 8'hD9, 1'b1, 1'b0, 1'b0},
    '{8'h42, 8'h42, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1},
    '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0},
    '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0},
    '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1},
    '{8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1},
    '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0},
    '{8'hA5, 8'h5A, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1},
    '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1},
    '{8'h7F, 8'hFF, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0}
  };

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       cin;
  logic       flush;
  logic       out_ready;

  logic       rdy_w [4];
  logic       ov_w  [4];
  logic [7:0] res_w [4];
  logic       co_w  [4];
  logic       of_w  [4];
  logic       z_w   [4];

  exp_t        sb [4][$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int DG = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8;
    localparam int NG = 8 / DG;
    logic ovp = 1'b0;
    exp_t e;

    addsub_serial #(.WIDTH(8), .DIGIT(DG)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (rdy_w[g]),
      .a        (a),
      .b        (b),
      .sub      (sub),
      .cin      (cin),
      .flush    (flush),
      .out_valid(ov_w[g]),
      .out_ready(out_ready),
      .result   (res_w[g]),
      .cout     (co_w[g]),
      .ovf      (of_w[g]),
      .zero     (z_w[g])
    );

    always @(negedge clk) begin
      if (rst_n) begin
        if (ov_w[g] && !ovp && sb[g].size() > 0) begin
          n_checks++;
          if (cyc - sb[g][0].acc != NG) begin
            n_fail++;
            $display("FAIL latency D=%0d: got %0d edges, want %0d", DG, cyc - sb[g][0].acc, NG);
          end
        end
        if (ov_w[g] && out_ready) begin
          n_checks++;
          if (sb[g].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output D=%0d: result=%h with no pending op", DG, res_w[g]);
          end else begin
            e = sb[g].pop_front();
            if ({res_w[g], co_w[g], of_w[g], z_w[g]} !== {e.res, e.co, e.ov, e.z}) begin
              n_fail++;
              $display("FAIL result D=%0d: got res=%h c=%b v=%b z=%b, want res=%h c=%b v=%b z=%b",
                       DG, res_w[g], co_w[g], of_w[g], z_w[g], e.res, e.co, e.ov, e.z);
            end
          end
        end
      end
      ovp = ov_w[g];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit all_rdy();
    return rdy_w[0] && rdy_w[1] && rdy_w[2] && rdy_w[3];
  endfunction

  function automatic bit any_ov();
    return ov_w[0] || ov_w[1] || ov_w[2] || ov_w[3];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic issue(input vec_t v, input bit push);
    int t = 0;
    while (!all_rdy() && t < 50) begin
      step();
      t++;
    end
    chk("issue_ready", 32'(all_rdy()), 32'd1);
    in_valid = 1'b1;
    a        = v.a;
    b        = v.b;
    sub      = v.sub;
    cin      = v.cin;
    step();
    in_valid = 1'b0;
    a        = ~v.a;
    b        = 8'h5A;
    sub      = ~v.sub;
    cin      = ~v.cin;
    if (push) begin
      for (int g = 0; g < 4; g++) begin
        sb[g].push_back('{res: v.res, co: v.co, ov: v.ov, z: v.z, acc: cyc});
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && t < 100) begin
      step();
      t++;
    end
    chk("drain", 32'(sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()), 32'd0);
  endtask

  initial begin
    bit bad;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    cin       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    for (int g = 0; g < 4; g++) begin
      chk("reset_outputs", {rdy_w[g], ov_w[g], res_w[g], co_w[g], of_w[g], z_w[g]}, '0);
    end
    rst_n = 1'b1;
    step();
    chk("idle_ready", 32'(all_rdy()), 32'd1);

    // Directed vectors across all digit sizes.
    foreach (vecs[i]) issue(vecs[i], 1'b1);
    drain();

    // Backpressure: hold result, ignore input pulses, release.
    out_ready = 1'b0;
    issue(vecs[1], 1'b1);
    for (int i = 0; i < 9; i++) step();
    for (int i = 0; i < 10; i++) begin
      bad = 1'b0;
      for (int g = 0; g < 4; g++) begin
        if (!ov_w[g] || rdy_w[g] || res_w[g] !== vecs[1].res || co_w[g] !== vecs[1].co) bad = 1'b1;
      end
      chk("backpressure_hold", 32'(bad), 32'd0);
      in_valid = i[0];
      a        = 8'hFF;
      b        = 8'hFF;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("release_ready", 32'(all_rdy()), 32'd1);
    drain();

    // Asynchronous reset mid-operation.
    out_ready = 1'b0;
    issue(vecs[0], 1'b0);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 4; g++) begin
      chk("reset_midop", {rdy_w[g], ov_w[g], res_w[g], co_w[g], of_w[g], z_w[g]}, '0);
    end
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_reset_ready", 32'(all_rdy()), 32'd1);

    // Flush during RUN/DONE.
    out_ready = 1'b0;
    issue(vecs[3], 1'b0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_no_valid", 32'(any_ov()), 32'd0);
    chk("flush_idle", 32'(all_rdy()), 32'd1);
    out_ready = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (any_ov()) bad = 1'b1;
    end
    chk("flush_quiet", 32'(bad), 32'd0);

    // Flush in IDLE drops a simultaneous input.
    flush    = 1'b1;
    in_valid = 1'b1;
    a        = 8'h12;
    b        = 8'h34;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("idle_flush_drop", 32'(all_rdy()), 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (any_ov()) bad = 1'b1;
    end
    chk("idle_flush_quiet", 32'(bad), 32'd0);

    issue(vecs[2], 1'b1);
    issue(vecs[4], 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
